// File: rtl/wb_sched_if.sv
//------------------------------------------------------------------------------
// wb_sched_if : handshake/bus bundle between the layer FSM side and wb_sched.
// Rev 1.0 - initial release. Optional perf_stall when WB_SCHED_PERF_EN is set.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface wb_sched_if;
  logic        start;
  logic [3:0]  layer;
  logic        pe_valid;
  logic        pe_ready;
  logic        wb_en;
  logic        finish_wb;
  logic [11:0] addr_base_1;
  logic [11:0] addr_base_2;
  logic        host_req;
  logic        host_gnt;
  logic        busy;
  logic        done;
  logic        err;
`ifdef WB_SCHED_PERF_EN
  logic [15:0] perf_stall;
`endif

  modport master (
`ifdef WB_SCHED_PERF_EN
    input  perf_stall,
`endif
    output start, layer, pe_valid, host_req,
    input  pe_ready, wb_en, finish_wb, addr_base_1, addr_base_2,
    input  host_gnt, busy, done, err
  );

  modport slave (
`ifdef WB_SCHED_PERF_EN
    output perf_stall,
`endif
    input  start, layer, pe_valid, host_req,
    output pe_ready, wb_en, finish_wb, addr_base_1, addr_base_2,
    output host_gnt, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/wb_sched.sv
//------------------------------------------------------------------------------
// wb_sched : layer sequencer for PE-group writeback, row flush, base addresses
//            and BRAM32k write-port arbitration. Macro: WB_SCHED_PERF_EN.
// Rev 1.0 - initial release.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef Layer1
`define Layer1 4'd1
`endif

module wb_sched #(
  parameter int BYTES_PER_WORD = 8,
  parameter int WORDS_PER_ROW  = 5,
  parameter int ROWS           = 28,
  parameter int BASE2          = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_sched_if.slave   bus
);

  localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WW = (WORDS_PER_ROW  > 1) ? $clog2(WORDS_PER_ROW)  : 1;
  localparam int RW = (ROWS           > 1) ? $clog2(ROWS)           : 1;

  typedef enum logic [2:0] {IDLE, FILL, FLUSH1, FLUSH2, DONE} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   byte_cnt;
  logic [WW-1:0]   word_cnt;
  logic [RW-1:0]   row_cnt;
  logic [11:0]     base_1, base_2;
  logic            pe_ready, wb_en, finish_wb, host_gnt, busy, done, err;

  logic            go, accept, byte_last, word_last, row_last;
  logic            pe_ready_n, finish_n, busy_n, done_n, err_n, gnt_n;

  assign byte_last = (byte_cnt == BW'(BYTES_PER_WORD - 1));
  assign word_last = (word_cnt == WW'(WORDS_PER_ROW - 1));
  assign row_last  = (row_cnt  == RW'(ROWS - 1));
  assign accept    = (state == FILL) && bus.pe_valid;
  // A held host grant blocks starts entirely, so go implies no grant.
  assign go        = (state == IDLE) && bus.start && (bus.layer == `Layer1) && !host_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pe_ready_n = 1'b0;
    finish_n   = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    gnt_n      = 1'b0;
    case (state)
      IDLE:    if (go) state_n = FILL;
      FILL:    if (accept && byte_last && word_last) state_n = FLUSH1;
      FLUSH1:  state_n = FLUSH2;
      FLUSH2:  state_n = row_last ? DONE : FILL;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered, so they are derived from the upcoming state.
    pe_ready_n = (state_n == FILL);
    finish_n   = (state_n == FLUSH1) || (state_n == FLUSH2);
    busy_n     = (state_n == FILL) || finish_n;
    done_n     = (state_n == DONE);
    err_n      = (state == IDLE) && bus.start && !host_gnt && (bus.layer != `Layer1);
    gnt_n      = host_gnt ? bus.host_req : ((state == IDLE) && bus.host_req && !go);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_ready  <= 1'b0;
      wb_en     <= 1'b0;
      finish_wb <= 1'b0;
      host_gnt  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      row_cnt   <= '0;
      base_1    <= '0;
      base_2    <= 12'(BASE2);
    end else begin
      pe_ready  <= pe_ready_n;
      wb_en     <= accept;
      finish_wb <= finish_n;
      host_gnt  <= gnt_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      if (go) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        row_cnt  <= '0;
        base_1   <= '0;
        base_2   <= 12'(BASE2);
      end else begin
        if (accept) begin
          if (byte_last) begin
            byte_cnt <= '0;
            word_cnt <= word_last ? '0 : word_cnt + WW'(1);
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
        if (state == FLUSH2) begin
          base_1  <= base_1 + 12'(WORDS_PER_ROW);
          base_2  <= base_2 + 12'(WORDS_PER_ROW);
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end
      end
    end
  end

`ifdef WB_SCHED_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_cnt <= '0;
    else if (go)
      perf_cnt <= '0;
    else if ((state == FILL) && !bus.pe_valid && (perf_cnt != 16'hFFFF))
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign bus.perf_stall = perf_cnt;
`endif

  assign bus.pe_ready    = pe_ready;
  assign bus.wb_en       = wb_en;
  assign bus.finish_wb   = finish_wb;
  assign bus.addr_base_1 = base_1;
  assign bus.addr_base_2 = base_2;
  assign bus.host_gnt    = host_gnt;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err;

endmodule

`default_nettype wire

// File: tb/tb_wb_sched.sv
//------------------------------------------------------------------------------
// tb_wb_sched : self-checking bench for wb_sched with a writeback scoreboard.
// Rev 1.0 - initial release. Honours WB_SCHED_PERF_EN when defined.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef Layer1
`define Layer1 4'd1
`endif

module tb_wb_sched;
  localparam int ROWS  = 28;
  localparam int WPR   = 5;
  localparam int BPW   = 8;
  localparam int SETS  = BPW * WPR;
  localparam int BASE2 = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_sched_if bus();

  wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [23:0] sbq[$];
  logic [23:0] sb_exp;

  // Each wb_en must match one queued accept and carry that row's bases.
  always @(negedge clk) begin
    if (rst && bus.wb_en === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        if (bad < 20) $display("FAIL wb_en_unexpected got=1 want=0 t=%0t", $time);
      end else begin
        sb_exp = sbq.pop_front();
        if ({bus.addr_base_1, bus.addr_base_2} !== sb_exp) begin
          bad++;
          if (bad < 20)
            $display("FAIL wb_bases got=%0d/%0d want=%0d/%0d", bus.addr_base_1,
                     bus.addr_base_2, sb_exp[23:12], sb_exp[11:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input bit toggle, input int host_mode, input int abort_row,
                          output int done_cyc, output int first_fin,
                          output int perf_row0, output bit aborted);
    int ms, fl, acc, row, exp_perf;
    logic [5:0] want;
    bus.start    = 1'b1;
    bus.layer    = `Layer1;
    bus.pe_valid = 1'b0;
    if (host_mode == 2) bus.host_req = 1'b1;
    tick();
    bus.start = 1'b0;
    ms = 0; fl = 0; acc = 0; exp_perf = 0;
    done_cyc = -1; first_fin = -1; perf_row0 = -1; aborted = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      want = {ms == 0, ms == 1, ms == 2, ms < 2, 1'b0, 1'b0};
      total++;
      if ({bus.pe_ready, bus.finish_wb, bus.done, bus.busy, bus.host_gnt, bus.err} !== want) begin
        bad++;
        if (bad < 20)
          $display("FAIL pass_ctrl c=%0d got=%b want=%b", c,
                   {bus.pe_ready, bus.finish_wb, bus.done, bus.busy, bus.host_gnt, bus.err}, want);
      end
`ifdef WB_SCHED_PERF_EN
      total++;
      if (bus.perf_stall !== exp_perf[15:0]) begin
        bad++;
        if (bad < 20) $display("FAIL perf_stall c=%0d got=%0d want=%0d", c, bus.perf_stall, exp_perf);
      end
`endif
      if (ms == 1 && fl == 2 && first_fin < 0) begin
        first_fin = c;
`ifdef WB_SCHED_PERF_EN
        perf_row0 = int'(bus.perf_stall);
`endif
      end
      if (ms == 2) begin
        done_cyc = c;
        break;
      end
      if (abort_row >= 0 && ms == 1 && fl == 2 && acc == (abort_row + 1) * SETS) begin
        aborted = 1'b1;
        break;
      end
      bus.pe_valid = toggle ? c[0] : 1'b1;
      bus.start    = (c == 50) || (c == 60);
      bus.layer    = (c == 60) ? 4'd3 : `Layer1;
      if (host_mode == 1 && c == 5) bus.host_req = 1'b1;
      if (ms == 0) begin
        if (bus.pe_valid) begin
          row = acc / SETS;
          sbq.push_back({12'(row * WPR), 12'(BASE2 + row * WPR)});
          acc++;
          if (acc % SETS == 0) begin
            ms = 1;
            fl = 2;
          end
        end else begin
          exp_perf++;
        end
      end else begin
        fl--;
        if (fl == 0) ms = (acc == ROWS * SETS) ? 2 : 0;
      end
      tick();
    end
    bus.start    = 1'b0;
    bus.pe_valid = 1'b0;
    if (done_cyc < 0 && !aborted) begin
      total++;
      bad++;
      $display("FAIL pass_timeout got=no_done want=done");
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.layer = 4'd0; bus.pe_valid = 1'b0; bus.host_req = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus.pe_ready, bus.wb_en, bus.finish_wb, bus.host_gnt, bus.busy, bus.done, bus.err,
         bus.addr_base_1, bus.addr_base_2} !== {7'b0, 12'd0, 12'd32}) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%0d/%0d want=0/0/32", {bus.pe_ready, bus.wb_en,
               bus.finish_wb, bus.host_gnt, bus.busy, bus.done, bus.err}, bus.addr_base_1, bus.addr_base_2);
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({bus.pe_ready, bus.wb_en, bus.finish_wb, bus.host_gnt, bus.busy, bus.done, bus.err,
         bus.addr_base_1, bus.addr_base_2} !== {7'b0, 12'd0, 12'd32}) begin
      bad++;
      $display("FAIL idle_outputs got=%b want=0", {bus.pe_ready, bus.wb_en, bus.busy, bus.err});
    end
  endtask

  task automatic test_bad_layer();
    bus.start = 1'b1;
    bus.layer = 4'd3;
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.err, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL bad_layer_pulse got=%b want=10", {bus.err, bus.busy});
    end
    tick();
    total++;
    if ({bus.err, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL bad_layer_after got=%b want=00", {bus.err, bus.busy});
    end
  endtask

  task automatic test_full_pass();
    int dc, ff, pr;
    bit ab;
    run_pass(1'b0, 0, -1, dc, ff, pr, ab);
    total++;
    if (dc !== 1176) begin
      bad++;
      $display("FAIL done_latency got=%0d want=1176", dc);
    end
    total++;
    if (ff !== 40) begin
      bad++;
      $display("FAIL row_fill_len got=%0d want=40", ff);
    end
    repeat (3) tick();
    total++;
    if ({bus.addr_base_1, bus.addr_base_2} !== {12'd140, 12'd172}) begin
      bad++;
      $display("FAIL final_bases got=%0d/%0d want=140/172", bus.addr_base_1, bus.addr_base_2);
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end
  endtask

  task automatic test_stall();
    int dc, ff, pr;
    bit ab;
    run_pass(1'b1, 0, -1, dc, ff, pr, ab);
    total++;
    if (ff !== 80) begin
      bad++;
      $display("FAIL stall_row_len got=%0d want=80", ff);
    end
    total++;
    if (dc !== ROWS * 82) begin
      bad++;
      $display("FAIL stall_done got=%0d want=%0d", dc, ROWS * 82);
    end
`ifdef WB_SCHED_PERF_EN
    total++;
    if (pr !== 40) begin
      bad++;
      $display("FAIL perf_row0 got=%0d want=40", pr);
    end
`endif
    tick();
  endtask

  task automatic host_after_done();
    tick();
    total++;
    if (bus.host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL gnt_idle1 got=%b want=0", bus.host_gnt);
    end
    tick();
    total++;
    if (bus.host_gnt !== 1'b1) begin
      bad++;
      $display("FAIL gnt_rise got=%b want=1", bus.host_gnt);
    end
    bus.start = 1'b1;
    bus.layer = `Layer1;
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.err, bus.host_gnt} !== 3'b001) begin
      bad++;
      $display("FAIL start_under_gnt got=%b want=001", {bus.busy, bus.err, bus.host_gnt});
    end
    bus.host_req = 1'b0;
    tick();
    total++;
    if (bus.host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL gnt_fall got=%b want=0", bus.host_gnt);
    end
  endtask

  task automatic test_host_during_pass();
    int dc, ff, pr;
    bit ab;
    run_pass(1'b0, 1, -1, dc, ff, pr, ab);
    host_after_done();
  endtask

  task automatic test_start_host_same();
    int dc, ff, pr;
    bit ab;
    run_pass(1'b0, 2, -1, dc, ff, pr, ab);
    host_after_done();
  endtask

  task automatic test_reset_midpass();
    int dc, ff, pr;
    bit ab;
    run_pass(1'b0, 0, 3, dc, ff, pr, ab);
    total++;
    if (ab !== 1'b1) begin
      bad++;
      $display("FAIL reach_flush_row3 got=%b want=1", ab);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({bus.pe_ready, bus.wb_en, bus.finish_wb, bus.host_gnt, bus.busy, bus.done, bus.err,
         bus.addr_base_1, bus.addr_base_2} !== {7'b0, 12'd0, 12'd32}) begin
      bad++;
      $display("FAIL async_reset got=%b/%0d/%0d want=0/0/32", {bus.pe_ready, bus.wb_en,
               bus.finish_wb, bus.busy}, bus.addr_base_1, bus.addr_base_2);
    end
`ifdef WB_SCHED_PERF_EN
    total++;
    if (bus.perf_stall !== 16'd0) begin
      bad++;
      $display("FAIL async_reset_perf got=%0d want=0", bus.perf_stall);
    end
`endif
    sbq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.wb_en, bus.busy, bus.pe_ready} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset_glitch got=%b want=000", {bus.wb_en, bus.busy, bus.pe_ready});
      end
    end
    run_pass(1'b0, 0, -1, dc, ff, pr, ab);
    total++;
    if (dc !== 1176) begin
      bad++;
      $display("FAIL restart_done got=%0d want=1176", dc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bad_layer();
    test_full_pass();
    test_stall();
    test_host_during_pass();
    test_start_host_same();
    test_reset_midpass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_sched.md
# wb_sched

Layer-level sequencer for the PE-group writeback path. It accepts one sum set per cycle from the PE groups and gates writeback with `wb_en`. It inserts the two-cycle end-of-row flush (`finish_wb`), advances per-row BRAM32k base addresses for both output channels, and arbitrates the BRAM32k write port between the writeback path and a host loader. It sits between the top-level layer FSM and the writeback block.

## Interface
- `BYTES_PER_WORD`, 8: sums packed per 64-bit BRAM word.
- `WORDS_PER_ROW`, 5: BRAM words per output row.
- `ROWS`, 28: output rows per layer pass.
- `BASE2`, 32: initial channel-2 base address.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a layer pass.
- `layer`  in  4  layer code, sampled on `start`. Only `` `Layer1`` is supported.
- `pe_valid`  in  1  PE groups present one sum set this cycle.
- `pe_ready`  out  1  the set is accepted when `pe_valid & pe_ready`.
- `wb_en`  out  1  writeback enable for the accepted set.
- `finish_wb`  out  1  row flush strobe to writeback.
- `addr_base_1`  out  12  channel-1 row base address.
- `addr_base_2`  out  12  channel-2 row base address.
- `host_req`  in  1  host requests the BRAM32k write port.
- `host_gnt`  out  1  host owns the port.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse at pass end.
- `err`  out  1  one-cycle pulse when `start` carries an unsupported layer.

## Operation
- States: IDLE, FILL, FLUSH1, FLUSH2, DONE.
- Counters:
  - `byte_cnt`: 0..BYTES_PER_WORD-1.
  - `word_cnt`: 0..WORDS_PER_ROW-1.
  - `row_cnt`: 0..ROWS-1.
  - All counters clear on entry to FILL from IDLE.
- IDLE:
  - `start` with `layer` equal to `` `Layer1`` and `host_gnt` = 0: go to FILL, set `busy`.
  - `start` with any other layer: pulse `err`, stay in IDLE.
  - `start` while `host_gnt` = 1: ignored, no `err`.
- FILL:
  - `pe_ready` = 1.
  - Each accepted set increments `byte_cnt`. On wrap, `word_cnt` increments.
  - On the accept that completes word WORDS_PER_ROW-1, go to FLUSH1.
- FLUSH1 and FLUSH2:
  - `pe_ready` = 0 and `finish_wb` = 1.
  - On FLUSH2 exit, both bases increment by WORDS_PER_ROW and `row_cnt` increments.
  - If the completed row was ROWS-1, go to DONE. Otherwise return to FILL.
- DONE: pulse `done`, clear `busy`, go to IDLE. Bases hold their values until the next `start`.
- Base reload on `start`: `addr_base_1` ← 0, `addr_base_2` ← BASE2. Additions wrap modulo 4096.
- Arbitration:
  - `host_gnt` may rise only in IDLE.
  - A host grant is held until `host_req` falls.
  - The writeback path never preempts the host. The host is never granted while `busy`.
  - Simultaneous `start` and `host_req` in IDLE: the writeback path wins, `host_gnt` stays 0.

## Timing
- Reset values: `pe_ready`=0, `wb_en`=0, `finish_wb`=0, `addr_base_1`=0, `addr_base_2`=BASE2, `host_gnt`=0, `busy`=0, `done`=0, `err`=0. State is IDLE and all counters are 0.
- All outputs are registered.
- `wb_en` follows an accepted `pe_valid` by exactly 1 cycle.
- `busy` rises the cycle after `start`.
- `host_gnt` rises 1 cycle after `host_req` is seen in IDLE. It falls 1 cycle after `host_req` drops.
- Row cost is 40 accepted sets plus 2 flush cycles, with `pe_valid` held high.
- A full pass with continuous `pe_valid` takes 28 × 42 cycles from the FILL entry, followed by 1 DONE cycle.
- `pe_valid` low in FILL stalls all counters and drives `wb_en` = 0.
- `start` while `busy` is ignored.
- Reset mid-pass: every output returns to its reset value immediately (asynchronous) and no write-enable glitch follows deassertion.

## Configuration
- `WB_SCHED_PERF_EN` defined:
  - Adds output `perf_stall` [15:0], counting FILL cycles with `pe_valid` = 0.
  - The counter saturates at 16'hFFFF and clears on `start`.
- `WB_SCHED_PERF_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Test plan
- Reset then `start` with `layer`=`` `Layer1`` and `pe_valid` held high:
  - `wb_en` is high 40 cycles per row.
  - `finish_wb` is high 2 cycles per row.
  - `done` pulses exactly 1176 cycles after FILL entry.
  - Final `addr_base_1`=140, `addr_base_2`=172.
- `start` with `layer`=4'd3 → one-cycle `err`, `busy` stays 0.
- `pe_valid` toggling 1/0 in FILL → row takes 80 + 2 cycles. With the macro, `perf_stall` = 40 after row 0.
- `host_req` raised during a pass → `host_gnt` stays 0 until 1 cycle after `done`. It then rises, and a `start` issued meanwhile is ignored.
- `start` and `host_req` in the same IDLE cycle → `busy`=1, `host_gnt`=0.
- `rst` low during FLUSH1 of row 3 → all outputs return to reset values at once. A new `start` restarts at base 0/32.
